// File: rtl/param_bit_counter.sv
// Multi-mode bit counter: accepts one WIDTH-bit word over Valid/Ready and scans it STEP bits per cycle, MSB chunk first.
// Optional BITCNT_EARLY_EXIT_EN: leading-zero mode finishes on the chunk that holds the first one bit.
module param_bit_counter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] DataIn,
  output logic             Ready,
  output logic             Done,
  output logic [WIDTH-1:0] DataOut
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int N  = WIDTH / STEP;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("param_bit_counter: WIDTH must be >= 2");
  end
  if (WIDTH % STEP != 0) begin : g_bad_step
    $error("param_bit_counter: WIDTH must be a multiple of STEP");
  end

  // Handshake: a word transfers on a rising edge where Valid && Ready are both 1;
  // Valid while Ready=0 is ignored, and DataIn/Mode are sampled only on that edge.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;

  logic [WIDTH-1:0] word;
  logic [1:0]       mode;
  logic             sign;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic             found;

  logic [STEP-1:0]  chunk;
  logic [STEP-1:0]  eq;
  logic [CW-1:0]    ones;
  logic [CW-1:0]    eq_cnt;
  logic [CW-1:0]    lz;
  logic [CW-1:0]    inc;
  logic [CW-1:0]    next_count;
  logic             chunk_zero;
  logic             hit;
  logic             last;

  // The word is shifted left each RUN cycle, so the current chunk is always on top.
  assign chunk      = word[WIDTH-1 -: STEP];
  assign chunk_zero = (chunk == '0);

  always_comb begin
    eq = sign ? chunk : ~chunk;
    if (idx == '0) eq[STEP-1] = 1'b0;
    ones   = '0;
    eq_cnt = '0;
    lz     = '0;
    hit    = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      ones   = ones + CW'(chunk[i]);
      eq_cnt = eq_cnt + CW'(eq[i]);
      if (!hit) begin
        if (chunk[i]) hit = 1'b1;
        else          lz  = lz + CW'(1);
      end
    end
    case (mode)
      2'd0:    inc = ones;
      2'd1:    inc = CW'(STEP) - ones;
      2'd2:    inc = eq_cnt;
      default: inc = found ? '0 : lz;
    endcase
    next_count = count + inc;
    last = (idx == IW'(N - 1));
`ifdef BITCNT_EARLY_EXIT_EN
    if (mode == 2'd3 && !found && !chunk_zero) last = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      Ready   <= 1'b1;
      Done    <= 1'b0;
      DataOut <= '0;
      word    <= '0;
      mode    <= '0;
      sign    <= 1'b0;
      count   <= '0;
      idx     <= '0;
      found   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Valid) begin
            word  <= DataIn;
            mode  <= Mode;
            sign  <= DataIn[WIDTH-1];
            count <= '0;
            idx   <= '0;
            found <= 1'b0;
            Ready <= 1'b0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          count <= next_count;
          word  <= word << STEP;
          idx   <= idx + IW'(1);
          if (mode == 2'd3 && !chunk_zero) found <= 1'b1;
          if (last) begin
            DataOut <= WIDTH'(next_count);
            Done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          Done  <= 1'b0;
          Ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/param_bit_counter.md
# param_bit_counter

Parametrised, multi-mode successor to the team's serial bit counter. It accepts one WIDTH-bit word over a Valid/Ready handshake and scans it STEP bits per cycle. It returns one of four counts: ones, zeros, sign-relative, or leading zeros. It sits behind a register-interface producer in the datapath and reports completion with a one-cycle Done strobe.

## Interface
Parameters:
- WIDTH, 32: input word width; must be ≥ 2.
- STEP, 4: bits processed per cycle; WIDTH % STEP must be 0, else `$error` at elaboration. N = WIDTH/STEP RUN cycles.
- Localparam CW = $clog2(WIDTH+1): internal count width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- Valid  input  1  producer has a word on DataIn/Mode.
- Mode  input  2  0 = ones, 1 = zeros, 2 = sign-relative, 3 = leading zeros.
- DataIn  input  WIDTH  word to count.
- Ready  output  1  block idle and able to accept.
- Done  output  1  one-cycle strobe; DataOut is valid from this cycle on.
- DataOut  output  WIDTH  result, zero-extended from CW bits; held until the next result or reset.

## Operation
- States:
  - IDLE: Ready=1.
  - RUN: Ready=0.
  - DONE: Ready=0, Done=1.
- IDLE → RUN on Valid && Ready. The accept edge does the following:
  - captures DataIn into word and Mode into mode;
  - clears count, idx and found.
- Valid while Ready=0 is ignored. DataIn and Mode are sampled only at accept.
- RUN processes one chunk per edge, chunk idx = word[WIDTH-1-idx·STEP -: STEP], MSB chunk first. Per mode:
  - Mode 0: count += popcount(chunk).
  - Mode 1: count += STEP − popcount(chunk).
  - Mode 2: count the bits in word[WIDTH-2:0] equal to word[WIDTH-1]. The MSB itself is masked out of chunk 0.
  - Mode 3: while found=0:
    - if the chunk is all zero, count += STEP;
    - otherwise count += leading zeros of the chunk, and found ← 1.
    - No further additions once found=1.
    - An all-zero word gives WIDTH.
- RUN → DONE on the last chunk (idx == N−1). That same edge writes DataOut ← the final count, including the last chunk's contribution.
- DONE → IDLE unconditionally after one cycle.
- Reset: state=IDLE, Ready=1, Done=0, DataOut=0, internal registers cleared. Reset mid-RUN or mid-DONE aborts the word: no Done, DataOut=0.
- Arithmetic: count is CW bits wide and cannot overflow, since the maximum is WIDTH.

## Timing
- Accept at edge E0. RUN covers edges E1..EN. DataOut updates and Done rises after EN.
- Ready rises after EN+1. The earliest next accept is EN+2. Throughput is one word per N+2 cycles.
- Edge cases:
  - STEP = WIDTH: N=1, latency 2 cycles.
  - STEP = 1: N = WIDTH.
- Done is never asserted in the same cycle as Ready.

## Configuration
- Macro BITCNT_EARLY_EXIT_EN.
- Defined: in mode 3, the edge that sets found is treated as the last chunk. It goes to DONE with DataOut written at that edge, so latency is idx_found+1 RUN cycles.
  - A word with MSB=1 finishes after 1 RUN cycle with DataOut=0.
  - Other modes are unchanged.
- Undefined: every mode always takes N RUN cycles. The found flag only gates accumulation.

## Test plan
All scenarios use WIDTH=32, STEP=4 (N=8).
- Reset: hold rst 2 cycles with Valid=1 → Ready=1, Done=0, DataOut=0; no accept during reset.
- Mode 0, DataIn=0xF0F0_0001 → DataOut=9, Done high exactly in the cycle after the 8th RUN edge; Ready high one cycle later.
- Mode 1, DataIn=0x0000_0000 → 32. Mode 2 results:
  - 0x8000_0003 → 2.
  - 0x0000_0003 → 29.
  - 0xFFFF_FFFF → 31.
- Mode 3:
  - 0x0001_0000 → 15. With BITCNT_EARLY_EXIT_EN, Done follows the 4th RUN edge; without it, the 8th.
  - 0x0000_0000 → 32 after 8 RUN cycles in both builds.
  - 0x8000_0000 → 0, after 1 RUN cycle with the macro.
- Hold Valid=1 with changing DataIn/Mode throughout RUN → only the first word counted. The second word is accepted at the first edge where Ready=1 (EN+2).
- Assert rst for one cycle at RUN idx=5 → IDLE next cycle, no Done, DataOut=0. A new word is then processed correctly.
